// File: rtl/sqrt_hs.sv
// sqrt_hs: iterative unsigned fixed-point square root with valid/ready handshakes.
// Computes T = floor(sqrt(rad << FRACTION_WIDTH)) with a restoring digit
// recurrence, STEPS_PER_CYCLE root bits per clock, and optionally rounds
// the root to nearest.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   in_valid/ready  - operand handshake (rad, round_en), ready only when idle
//   rad, round_en   - radicand (Q(TOTAL_WIDTH-FRACTION_WIDTH).FRACTION_WIDTH), rounding enable
//   abort           - drop the operation in flight (ignored while idle)
//   busy            - recurrence running
//   out_valid/ready - result handshake
//   root, rem       - root (same Q format as rad) and unrounded remainder
//   rounded_up      - root was incremented by rounding
module sqrt_hs #(
  parameter int unsigned TOTAL_WIDTH     = 16,
  parameter int unsigned FRACTION_WIDTH  = 8,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] rad,
  input  logic                   round_en,
  input  logic                   abort,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] root,
  output logic [TOTAL_WIDTH-1:0] rem,
  output logic                   rounded_up
);

  localparam int unsigned NW     = TOTAL_WIDTH + FRACTION_WIDTH;
  localparam int unsigned ITER   = NW / 2;
  localparam int unsigned RW     = ITER + 2;
  localparam int unsigned CYCLES = ITER / STEPS_PER_CYCLE;
  localparam int unsigned CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  // Parameter legality
  if ((NW % 2) != 0) begin : g_err_odd
    $error("sqrt_hs: TOTAL_WIDTH+FRACTION_WIDTH must be even");
  end
  if (FRACTION_WIDTH + 2 > TOTAL_WIDTH) begin : g_err_frac
    $error("sqrt_hs: FRACTION_WIDTH must not exceed TOTAL_WIDTH-2");
  end
  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4) begin : g_err_steps
    $error("sqrt_hs: STEPS_PER_CYCLE must be 1, 2 or 4");
  end
  if ((ITER % STEPS_PER_CYCLE) != 0) begin : g_err_div
    $error("sqrt_hs: ITER must be a multiple of STEPS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NW-1:0]   rad_sh;   // radicand bits not yet consumed, MSB pair first
  logic [RW-1:0]   part_rem;
  logic [ITER-1:0] part_root;
  logic            round_q;

  logic [NW-1:0]   rad_sh_n;
  logic [RW-1:0]   part_rem_n;
  logic [ITER-1:0] part_root_n;
  logic [RW-1:0]   rem_sh;
  logic [RW-1:0]   trial;
  logic            up_c;

  // STEPS_PER_CYCLE restoring recurrence steps: bring down two radicand bits,
  // try subtracting 4*root+1, keep the result if it did not go negative.
  // The running remainder is bounded by 2*root, so its top two bits are
  // always zero before the shift.
  always_comb begin
    rad_sh_n    = rad_sh;
    part_rem_n  = part_rem;
    part_root_n = part_root;
    rem_sh      = '0;
    trial       = '0;
    for (int i = 0; i < int'(STEPS_PER_CYCLE); i++) begin
      rem_sh = {part_rem_n[RW-3:0], rad_sh_n[NW-1 -: 2]};
      trial  = {part_root_n, 2'b01};
      if (rem_sh >= trial) begin
        part_rem_n  = rem_sh - trial;
        part_root_n = ITER'({part_root_n, 1'b1});
      end else begin
        part_rem_n  = rem_sh;
        part_root_n = ITER'({part_root_n, 1'b0});
      end
      rad_sh_n = rad_sh_n << 2;
    end
  end

  // Round to nearest when the remainder exceeds the truncated root
  assign up_c = round_q && (part_rem_n > RW'(part_root_n));

  // Control FSM with registered handshake flags and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      root       <= '0;
      rem        <= '0;
      rounded_up <= 1'b0;
      cnt        <= '0;
      rad_sh     <= '0;
      part_rem   <= '0;
      part_root  <= '0;
      round_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_CALC;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            rad_sh    <= NW'(rad) << FRACTION_WIDTH;
            round_q   <= round_en;
            part_rem  <= '0;
            part_root <= '0;
            cnt       <= '0;
          end
        end
        S_CALC: begin
          if (abort) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            rad_sh    <= rad_sh_n;
            part_rem  <= part_rem_n;
            part_root <= part_root_n;
            cnt       <= cnt + CW'(1);
            if (cnt == CW'(CYCLES - 1)) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              out_valid  <= 1'b1;
              root       <= TOTAL_WIDTH'(part_root_n) + TOTAL_WIDTH'(up_c);
              rem        <= TOTAL_WIDTH'(part_rem_n);
              rounded_up <= up_c;
            end
          end
        end
        S_DONE: begin
          // in_ready rises only after the output handshake edge
          if (abort || out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_hs.sv
// tb_sqrt_hs: self-checking bench for sqrt_hs with STEPS_PER_CYCLE = 1, 2, 4.
// Expected results come from an arithmetic square-root model; one monitor
// compares every valid output cycle of all three instances against it.
module tb_sqrt_hs;

  typedef struct packed {
    logic [15:0] root;
    logic [15:0] rem;
    logic        up;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0]       in_valid  = '0;
  logic [2:0]       round_en  = '0;
  logic [2:0]       abort     = '0;
  logic [2:0]       out_ready = '1;
  logic [2:0][15:0] rad       = '0;
  wire  [2:0]       in_ready, busy, out_valid, rounded_up;
  wire  [2:0][15:0] root, rem;

  exp_t expq [3][$];
  int   acc_cyc [3];
  logic prev_valid [3];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [15:0] vec_rad [6] = '{16'hE890, 16'h0040, 16'h0200, 16'hFFFF, 16'hFFFF, 16'h0000};
  logic        vec_rnd [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sqrt_hs #(
      .TOTAL_WIDTH(16),
      .FRACTION_WIDTH(8),
      .STEPS_PER_CYCLE(1 << g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .rad       (rad[g]),
      .round_en  (round_en[g]),
      .abort     (abort[g]),
      .busy      (busy[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .root      (root[g]),
      .rem       (rem[g]),
      .rounded_up(rounded_up[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
  endtask

  // floor(sqrt(rad * 2^8)) by plain arithmetic, then optional round-to-nearest
  function automatic exp_t model(input logic [15:0] r, input logic re);
    longint n, t, rm;
    exp_t   e;
    n = longint'(r) << 8;
    t = longint'($rtoi($sqrt($itor(n))));
    while (t * t > n) t--;
    while ((t + 1) * (t + 1) <= n) t++;
    rm     = n - t * t;
    e.up   = re && (rm > t);
    e.root = 16'(t + (e.up ? 1 : 0));
    e.rem  = 16'(rm);
    return e;
  endfunction

  // Compare every valid output cycle, including latency on the rising cycle
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst && out_valid[k]) begin
        if (!prev_valid[k])
          chk($sformatf("latency[%0d]", k), longint'(cyc - acc_cyc[k]), longint'(12 >> k));
        if (expq[k].size() == 0) begin
          chk($sformatf("spurious_out_valid[%0d]", k), 1, 0);
        end else begin
          e = expq[k][0];
          chk($sformatf("root[%0d]", k), root[k], e.root);
          chk($sformatf("rem[%0d]", k), rem[k], e.rem);
          chk($sformatf("rounded_up[%0d]", k), rounded_up[k], e.up);
          if (out_ready[k]) void'(expq[k].pop_front());
        end
      end
      prev_valid[k] = !rst && out_valid[k];
    end
  end

  // Called and returns #1 after a rising edge
  task automatic send(input int k, input logic [15:0] r, input logic re);
    int t = 0;
    while (!in_ready[k] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready[k]) begin
      chk($sformatf("in_ready_timeout[%0d]", k), 0, 1);
      return;
    end
    in_valid[k] = 1'b1;
    rad[k]      = r;
    round_en[k] = re;
    expq[k].push_back(model(r, re));
    acc_cyc[k] = cyc + 1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    abort[k]    = 1'b0;
    rad[k]      = 16'($urandom);
    round_en[k] = 1'($urandom);
  endtask

  task automatic drain(input int k);
    int t = 0;
    while (expq[k].size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (expq[k].size() != 0) begin
      chk($sformatf("drain_timeout[%0d]", k), expq[k].size(), 0);
      expq[k].delete();
    end
  endtask

  initial begin
    exp_t m;
    int   t;
    int   prev_acc;

    // Model pinned to hand-computed values
    m = model(16'hE890, 1'b0);
    chk("model_e890_root", m.root, 16'h0F40);
    chk("model_e890_rem", m.rem, 16'h0000);
    m = model(16'h0040, 1'b0);
    chk("model_0040_root", m.root, 16'h0080);
    m = model(16'h0200, 1'b1);
    chk("model_0200_root", m.root, 16'h016A);
    chk("model_0200_rem", m.rem, 16'h001C);
    chk("model_0200_up", m.up, 0);
    m = model(16'hFFFF, 1'b1);
    chk("model_ffff_r_root", m.root, 16'h1000);
    chk("model_ffff_r_rem", m.rem, 16'h1EFF);
    chk("model_ffff_r_up", m.up, 1);
    m = model(16'hFFFF, 1'b0);
    chk("model_ffff_t_root", m.root, 16'h0FFF);
    m = model(16'h0000, 1'b1);
    chk("model_zero_root", m.root, 0);

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k), in_ready[k], 1);
      chk($sformatf("rst_busy[%0d]", k), busy[k], 0);
      chk($sformatf("rst_out_valid[%0d]", k), out_valid[k], 0);
      chk($sformatf("rst_root[%0d]", k), root[k], 0);
      chk($sformatf("rst_rem[%0d]", k), rem[k], 0);
      chk($sformatf("rst_rounded_up[%0d]", k), rounded_up[k], 0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors on every unroll factor
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 6; v++) send(k, vec_rad[v], vec_rnd[v]);
      drain(k);
    end

    // Backpressure: result held for 5 cycles, in_ready after the handshake
    out_ready[0] = 1'b0;
    send(0, 16'h9C41, 1'b1);
    t = 0;
    while (!out_valid[0] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_out_valid", out_valid[0], 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready_low", in_ready[0], 0);
      chk("bp_out_valid_held", out_valid[0], 1);
    end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    chk("bp_no_ready_in_handshake", in_ready[0], 0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp_in_ready_rises", in_ready[0], 1);
    chk("bp_out_valid_drop", out_valid[0], 0);
    chk("bp_not_accepted", busy[0], 0);
    drain(0);

    // Abort in CALC cycle 6, with in_valid also high
    send(0, 16'h5A5A, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    abort[0]    = 1'b1;
    in_valid[0] = 1'b1;
    expq[0].delete();
    @(posedge clk); #1;
    abort[0]    = 1'b0;
    in_valid[0] = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_in_ready", in_ready[0], 1);
    chk("abort_out_valid", out_valid[0], 0);
    repeat (20) @(posedge clk);
    #1;

    // Abort ignored while idle
    abort[0] = 1'b1;
    send(0, 16'h3039, 1'b0);
    drain(0);

    // Reset mid-CALC, then accept on the first edge after release
    send(0, 16'hFFFF, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    expq[0].delete();
    chk("midrst_in_ready", in_ready[0], 1);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_root", root[0], 0);
    chk("midrst_rem", rem[0], 0);
    chk("midrst_rounded_up", rounded_up[0], 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("postrst_in_ready", in_ready[0], 1);
    send(0, 16'hE890, 1'b0);
    drain(0);

    // Back-to-back random radicands, out_ready always 1
    for (int k = 0; k < 3; k++) begin
      prev_acc = 0;
      for (int i = 0; i < ((k == 0) ? 1000 : 300); i++) begin
        send(k, 16'($urandom), 1'($urandom));
        if (i > 0)
          chk($sformatf("accept_interval[%0d]", k), acc_cyc[k] - prev_acc, (12 >> k) + 2);
        prev_acc = acc_cyc[k];
      end
      drain(k);
    end

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
